poly_stream_engine: RTL
=======================

// Module: poly_stream_engine
// PURPOSE
//  Parametrised coefficient-wise polynomial engine: the successor to the fixed 96-bit ADD/SUB/MULT sequencer.
//  Streams words of LANES packed coefficients from operand A and operand B in an external single-port polynomial RAM.
//  Computes (a+b) mod Q or (a-b) mod Q per lane and writes the result words back at a third base address.
//  Sits beside the NTT core on the shared polynomial memory; a top-level controller sequences it with start/done.
// PARAMETERS
//  LANES    8     coefficients per memory word
//  COEF_W   12    bits per coefficient; 2^COEF_W > Q required
//  Q        3329  modulus
//  N_WORDS  32    words per polynomial (>=1)
//  ADDR_W   8     memory address width
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous reset, active-high
//  start      in   1              operation request, sampled only in IDLE
//  op         in   1              0 = add, 1 = sub; latched at start
//  a_base     in   ADDR_W         operand A base word address; latched at start
//  b_base     in   ADDR_W         operand B base word address; latched at start
//  c_base     in   ADDR_W         result base word address; latched at start
//  r_en       out  1              memory read strobe
//  r_addr     out  ADDR_W         memory read address
//  r_data     in   LANES*COEF_W   read data, valid exactly 1 cycle after r_en/r_addr
//  w_en       out  1              memory write strobe
//  w_addr     out  ADDR_W         memory write address
//  w_data     out  LANES*COEF_W   write data; lane k = bits [k*COEF_W +: COEF_W]
//  busy       out  1              high from the first RUN cycle through the done cycle
//  done       out  1              1-cycle pulse after the last write
//  range_err  out  1              only with POLY_STREAM_RANGE_CHK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; r_en, w_en, busy, done, range_err = 0; r_addr, w_addr, w_data = 0; word counter = 0.
//  FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: if start, latch op and the three bases, then go to RUN. Otherwise hold all strobes low.
//   RUN: 2N_WORDS cycles; phase bit p toggles each cycle, word index i increments after odd phase.
//   DRAIN: 2 cycles, flushes the final word's pipeline.
//   DONE: 1 cycle; done=1. Then IDLE.
//  Per-word timing (t = 2i cycles after RUN entry):
//   t:   r_en=1, r_addr=a_base+i.
//   t+1: r_en=1, r_addr=b_base+i; A[i] captured from r_data into a_reg.
//   t+2: B[i] on r_data; per-lane result computed and registered.
//   t+3: w_en=1, w_addr=c_base+i, w_data=result.
//  Throughput is 1 word per 2 cycles, and writes overlap the next word's reads.
//  First write lands 3 cycles after RUN entry; last write at 2N_WORDS+1; done 1 cycle later.
//  All address sums are modulo 2^ADDR_W (wrap, no error). Overlapping A/B/C regions are allowed.
//   Each result word is written 1 cycle after its B read, so in-place C=A or C=B is safe.
//  Arithmetic per lane, with operands assumed < Q:
//   add: s = a+b in COEF_W+1 bits; if s >= Q then s - Q.
//   sub: d = a-b in COEF_W+1 bits; if negative then d + Q.
//   Result is always in [0, Q-1].
//  start while not IDLE is ignored: no relatch, no restart. start in the DONE cycle is also ignored.
//  rst mid-operation: next cycle is IDLE with all strobes low; no partial write is issued after reset.
//  w_data holds its last value when w_en=0; r_addr returns to 0 when r_en=0.
// CONFIGURATION
//  POLY_STREAM_RANGE_CHK_EN defined:
//   Any lane of A or B >= Q sets range_err (sticky). The result is still computed as specified.
//   range_err clears on rst or on an accepted start.
//  Not defined: range_err is tied 0 and the comparators are removed.
// TESTING
//  1. add, A lanes=3000, B lanes=1000, a/b/c_base=0/32/64 -> every written lane = 671; 32 writes to 64..95; done at RUN+2*32+2.
//  2. sub, A lanes=5, B lanes=10 -> lanes=3324; sub, A=10, B=5 -> lanes=5; A=B=0 -> lanes=0.
//  3. a_base=250, default N_WORDS -> A reads at 250..255, then 0..25 (wraps); data correct.
//  4. start pulsed at RUN+10 with different bases -> ignored; the original sequence completes unchanged; exactly one done pulse.
//  5. rst asserted at RUN+7 -> next cycle busy=0, w_en=0, r_en=0; a following start runs a clean full operation.
//  6. (with _EN) one lane of B[3]=3329 -> range_err=1 and held after done; cleared by the next start; stays 0 without _EN.

Source files
------------

// File: rtl/poly_stream_engine.sv
// rtl/poly_stream_engine.sv - streaming per-lane (a+b) mod Q / (a-b) mod Q engine over a single-port polynomial RAM
// Optional feature: POLY_STREAM_RANGE_CHK_EN adds a sticky range_err for operand lanes >= Q.
module poly_stream_engine #(
  parameter int LANES   = 8,
  parameter int COEF_W  = 12,
  parameter int Q       = 3329,
  parameter int N_WORDS = 32,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op,
  input  logic [ADDR_W-1:0]         a_base,
  input  logic [ADDR_W-1:0]         b_base,
  input  logic [ADDR_W-1:0]         c_base,
  output logic                      r_en,
  output logic [ADDR_W-1:0]         r_addr,
  input  logic [LANES*COEF_W-1:0]   r_data,
  output logic                      w_en,
  output logic [ADDR_W-1:0]         w_addr,
  output logic [LANES*COEF_W-1:0]   w_data,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int DW    = LANES * COEF_W;
  localparam logic [COEF_W:0] QW = (COEF_W+1)'(Q);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic              op_q;
  logic [ADDR_W-1:0] a_q, b_q, c_q;
  logic [IDX_W-1:0]  idx, b_idx;
  logic              phase, b_vld;
  logic [DW-1:0]     a_reg, result;
  logic              last_word;

  function automatic logic [COEF_W-1:0] lane_op(input logic sub, input logic [COEF_W-1:0] a,
                                                input logic [COEF_W-1:0] b);
    logic [COEF_W:0] s;
    if (!sub) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= QW) s = s - QW;
    end else begin
      s = {1'b0, a} - {1'b0, b};
      if (s[COEF_W]) s = s + QW;
    end
    return s[COEF_W-1:0];
  endfunction

  assign last_word = (idx == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (phase && last_word) state_nx = DRAIN;
      DRAIN:   if (phase) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign r_en   = (state == RUN);
  // Even phase reads A[i], odd phase reads B[i]; address parks at 0 when idle.
  assign r_addr = r_en ? ((phase ? b_q : a_q) + ADDR_W'(idx)) : '0;

  // r_data carries B[i] while b_vld is high; a_reg already holds A[i].
  always_comb begin
    result = '0;
    for (int k = 0; k < LANES; k++)
      result[k*COEF_W +: COEF_W] = lane_op(op_q, a_reg[k*COEF_W +: COEF_W], r_data[k*COEF_W +: COEF_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      idx    <= '0;
      phase  <= 1'b0;
      b_vld  <= 1'b0;
      b_idx  <= '0;
      a_reg  <= '0;
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      w_en  <= 1'b0;
      b_vld <= (state == RUN) && phase;
      b_idx <= idx;
      case (state)
        IDLE: begin
          phase <= 1'b0;
          idx   <= '0;
          if (start) begin
            op_q <= op;
            a_q  <= a_base;
            b_q  <= b_base;
            c_q  <= c_base;
          end
        end
        RUN: begin
          phase <= ~phase;
          if (phase) begin
            idx   <= idx + 1'b1;
            a_reg <= r_data;
          end
        end
        DRAIN:   phase <= ~phase;
        default: phase <= 1'b0;
      endcase
      if (b_vld) begin
        w_en   <= 1'b1;
        w_addr <= c_q + ADDR_W'(b_idx);
        w_data <= result;
      end
    end
  end

`ifdef POLY_STREAM_RANGE_CHK_EN
  function automatic logic any_ge_q(input logic [DW-1:0] w);
    logic r;
    r = 1'b0;
    for (int k = 0; k < LANES; k++)
      if ({1'b0, w[k*COEF_W +: COEF_W]} >= QW) r = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      range_err <= 1'b0;
    else if (state == IDLE && start)
      range_err <= 1'b0;
    else if (((state == RUN && phase) || b_vld) && any_ge_q(r_data))
      range_err <= 1'b1;
  end
`else
  assign range_err = 1'b0;
`endif

endmodule
